// File: rtl/key_event_pkg.sv
// Shared definitions for the key event queue: event type codes, FSM state
// encoding and the 7-bit event record {type, code} stored in the FIFO.
// Imported by key_event_fifo's users and by key_event_queue.
package key_event_pkg;

    localparam int CODE_W = 5;
    localparam int TYPE_W = 2;
    localparam int EV_W   = TYPE_W + CODE_W;

    // Event type field; 2'b00 never enters the FIFO and marks an empty head.
    localparam logic [TYPE_W-1:0] EV_NONE    = 2'b00;
    localparam logic [TYPE_W-1:0] EV_PRESS   = 2'b01;
    localparam logic [TYPE_W-1:0] EV_REPEAT  = 2'b10;
    localparam logic [TYPE_W-1:0] EV_RELEASE = 2'b11;

    // Key tracking FSM states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // One queued event; packs to exactly EV_W bits with type in the MSBs.
    typedef struct packed {
        logic [TYPE_W-1:0] ev_type;
        logic [CODE_W-1:0] code;
    } event_t;

    function automatic event_t make_event(input logic [TYPE_W-1:0] t,
                                          input logic [CODE_W-1:0] c);
        event_t e;
        e.ev_type = t;
        e.code    = c;
        return e;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Purpose     : synchronous first-word-fall-through FIFO with a registered head.
// Latency     : a push into an empty FIFO is visible on head_dat the cycle after the push edge.
// Backpressure: push while full without a same-cycle pop is ignored (caller flags the drop);
//               pop while empty is ignored.
// Ports: clk/rst_n clock and async active-low reset; push/push_dat write side;
//        pop read side; head_dat registered head entry (zero when empty);
//        empty/full status; count number of stored entries.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [W-1:0]     head_q;

    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [W-1:0]     head_nxt;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

        count_nxt = count_q;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase

        // The head register tracks the entry at the next read pointer. When
        // the entry being written lands exactly there (empty FIFO, or the last
        // entry leaving), it is forwarded straight from push_dat.
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = push_dat;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage needs no reset: entries are only observed through head_q,
    // which is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            head_q  <= head_nxt;
        end
    end

    assign head_dat = head_q;
    assign count    = count_q;

endmodule

// File: rtl/key_event_queue.sv
// Purpose     : turns the scanner's debounced key level into PRESS/REPEAT/RELEASE events and queues them.
// Latency     : key_ready sampled at edge N -> PRESS written at edge N+1 -> ev_valid high after N+1.
// Backpressure: consumer pops with rd_en at its own pace; an event arriving at a full queue
//               with no same-cycle pop is dropped and the sticky overflow flag is set.
// Ports: clk/rst_n clock and async active-low reset; key_ready/key_code scanner inputs;
//        rep_en enables auto-repeat; rd_en pops the head; ev_valid/ev_code/ev_type head event;
//        ev_count queue occupancy; overflow sticky drop flag, cleared by ovf_clr.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int CNT_W         = 25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_ready,
    input  logic [CODE_W-1:0]      key_code,
    input  logic                   rep_en,
    input  logic                   rd_en,
    output logic                   ev_valid,
    output logic [CODE_W-1:0]      ev_code,
    output logic [TYPE_W-1:0]      ev_type,
    output logic [$clog2(DEPTH):0] ev_count,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    // Input stage: every FSM decision is taken on these registered copies.
    logic              r_ready;
    logic [CODE_W-1:0] r_code;

    // Key tracking state.
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CODE_W-1:0] cur;
    logic [CODE_W-1:0] cur_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_limit;
    logic              key_gone;

    // FIFO interface.
    logic              push;
    event_t            push_ev;
    event_t            head_ev;
    logic              fifo_empty;
    logic              fifo_full;
    logic              drop;
    logic              overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_code  <= '0;
        end else begin
            r_ready <= key_ready;
            r_code  <= key_code;
        end
    end

    // A held key ends either by being released or by the scanner reporting a
    // different code (roll-over); both close the current key with a RELEASE.
    assign key_gone = !r_ready || (r_code != cur);

    // First repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
    assign cnt_limit = (state == ST_HELD) ? CNT_W'(REPEAT_DELAY - 1)
                                          : CNT_W'(REPEAT_PERIOD - 1);

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        cnt_nxt   = cnt;
        push      = 1'b0;
        push_ev   = make_event(EV_NONE, '0);

        case (state)
            ST_IDLE: begin
                if (r_ready) begin
                    push      = 1'b1;
                    push_ev   = make_event(EV_PRESS, r_code);
                    cur_nxt   = r_code;
                    cnt_nxt   = '0;
                    state_nxt = ST_HELD;
                end
            end

            ST_HELD, ST_REPEAT: begin
                // Release/change outranks a repeat due in the same cycle, so
                // at most one push is ever issued. After a roll-over, IDLE
                // picks up the new code on the following cycle.
                if (key_gone) begin
                    push      = 1'b1;
                    push_ev   = make_event(EV_RELEASE, cur);
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (!rep_en) begin
                    cnt_nxt = '0;
                end else if (cnt == cnt_limit) begin
                    push      = 1'b1;
                    push_ev   = make_event(EV_REPEAT, cur);
                    cnt_nxt   = '0;
                    state_nxt = ST_REPEAT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cur   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            cnt   <= cnt_nxt;
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_ev),
        .pop      (rd_en),
        .head_dat (head_ev),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (ev_count)
    );

    // Mirrors the FIFO's accept rule: a push is lost only when the queue is
    // full and the head is not leaving in the same cycle.
    assign drop = push && fifo_full && !(rd_en && !fifo_empty);

    // Sticky drop flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign ev_valid = !fifo_empty;
    assign ev_code  = head_ev.code;
    assign ev_type  = head_ev.ev_type;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue with short repeat timings (delay 8, period 4, depth 4).
module tb_key_event_queue;

    localparam int DEPTH = 4;
    localparam int RD    = 8;
    localparam int RP    = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       key_ready = 1'b0;
    logic [4:0] key_code  = 5'h00;
    logic       rep_en    = 1'b0;
    logic       rd_en     = 1'b0;
    logic       ovf_clr   = 1'b0;
    logic       ev_valid;
    logic [4:0] ev_code;
    logic [1:0] ev_type;
    logic [2:0] ev_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    key_event_queue #(
        .DEPTH         (DEPTH),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .CNT_W         (25)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_ready (key_ready),
        .key_code  (key_code),
        .rep_en    (rep_en),
        .rd_en     (rd_en),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_type   (ev_type),
        .ev_count  (ev_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    // Reference model: a queue of {type, code} events plus a description of
    // the key as seen one cycle late, how long rep_en has been on since the
    // last event, and how many repeats this key has produced.
    logic [6:0] m_q[$];
    bit         m_ovf;
    bit         m_rr;
    logic [4:0] m_rc;
    bit         m_down;
    logic [4:0] m_cur;
    int         m_run;
    int         m_reps;

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 0;
        m_rr   = 0;
        m_rc   = '0;
        m_down = 0;
        m_cur  = '0;
        m_run  = 0;
        m_reps = 0;
    endtask

    task automatic model_step();
        bit         pop_ok;
        bit         have;
        bit         drop;
        logic [6:0] ev;
        pop_ok = rd_en && (m_q.size() > 0);
        have   = 0;
        drop   = 0;
        ev     = '0;
        if (!m_down) begin
            if (m_rr) begin
                have   = 1;
                ev     = {2'b01, m_rc};
                m_down = 1;
                m_cur  = m_rc;
                m_run  = 0;
                m_reps = 0;
            end
        end else if (!m_rr || (m_rc != m_cur)) begin
            have   = 1;
            ev     = {2'b11, m_cur};
            m_down = 0;
        end else if (rep_en) begin
            m_run++;
            if (m_run == ((m_reps == 0) ? RD : RP)) begin
                have  = 1;
                ev    = {2'b10, m_cur};
                m_reps++;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (pop_ok) void'(m_q.pop_front());
        if (have) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        m_rr = key_ready;
        m_rc = key_code;
    endtask

    // Expected {ev_valid, ev_type, ev_code, ev_count, overflow}.
    function automatic logic [11:0] model_out();
        logic [6:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 7'd0;
        return {m_q.size() > 0, h, 3'(m_q.size()), m_ovf};
    endfunction

    function automatic logic [11:0] dut_out();
        return {ev_valid, ev_type, ev_code, ev_count, overflow};
    endfunction

    // One clock: the model advances with the DUT edge, then control returns
    // on the falling edge where outputs are sampled and inputs are changed.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if (dut_out() !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", dut_out(), 12'h000);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (dut_out() !== 12'h000 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", dut_out(), 12'h000);
        end
    endtask

    task automatic test_tap();
        rd_en = 0; rep_en = 0;
        key_code = 5'h0A; key_ready = 1;
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL tap_latency_n: ev_valid got %b expected 0", ev_valid);
        end
        tick();
        checks++;
        if ({ev_valid, ev_type, ev_code} !== {1'b1, 2'b01, 5'h0A}) begin
            errors++;
            $display("FAIL tap_press: got %b/%b/%h expected 1/01/0a", ev_valid, ev_type, ev_code);
        end
        tick();
        key_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL tap_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        checks++;
        if ({ev_count, ev_type, ev_code} !== {3'd2, 2'b01, 5'h0A}) begin
            errors++;
            $display("FAIL tap_queued: got cnt %0d %b/%h expected cnt 2 01/0a", ev_count, ev_type, ev_code);
        end
        rd_en = 1; tick(); rd_en = 0;
        checks++;
        if ({ev_valid, ev_count, ev_type, ev_code} !== {1'b1, 3'd1, 2'b11, 5'h0A}) begin
            errors++;
            $display("FAIL tap_release: got %b cnt %0d %b/%h expected 1 cnt 1 11/0a", ev_valid, ev_count, ev_type, ev_code);
        end
        rd_en = 1; tick(); rd_en = 0;
        checks++;
        if ({ev_valid, ev_count, ev_type} !== {1'b0, 3'd0, 2'b00}) begin
            errors++;
            $display("FAIL tap_empty: got %b cnt %0d type %b expected 0 cnt 0 type 00", ev_valid, ev_count, ev_type);
        end
    endtask

    task automatic test_hold_repeat();
        logic [6:0] got[$];
        int         when[$];
        logic [6:0] exp_ev [5];
        int         exp_gap [4];
        exp_ev  = '{7'h32, 7'h52, 7'h52, 7'h52, 7'h72};
        exp_gap = '{8, 4, 4, 4};
        rd_en = 1; rep_en = 1;
        key_code = 5'h12; key_ready = 1;
        for (int i = 0; i < 26; i++) begin
            if (i == 20) key_ready = 0;
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL hold_rep_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
            if (ev_valid) begin
                got.push_back({ev_type, ev_code});
                when.push_back(cyc);
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_ev[i]) begin
                errors++;
                $display("FAIL hold_rep_event%0d: got %h expected %h (seen %0d events)", i,
                         (i < got.size()) ? got[i] : 7'h00, exp_ev[i], got.size());
            end
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (i >= when.size() || (when[i] - when[i-1]) !== exp_gap[i-1]) begin
                errors++;
                $display("FAIL hold_rep_gap%0d: got %0d expected %0d", i,
                         (i < when.size()) ? when[i] - when[i-1] : -1, exp_gap[i-1]);
            end
        end
        rd_en = 0; rep_en = 0;
    endtask

    task automatic test_hold_no_repeat();
        logic [6:0] got[$];
        rd_en = 1; rep_en = 0;
        key_code = 5'h03; key_ready = 1;
        for (int i = 0; i < 26; i++) begin
            if (i == 20) key_ready = 0;
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL hold_norep_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
            if (ev_valid) got.push_back({ev_type, ev_code});
        end
        checks++;
        if (got.size() != 2 || got[0] !== 7'h23 || got[1] !== 7'h63) begin
            errors++;
            $display("FAIL hold_norep_events: got %0d events first %h expected 2 events 23,63",
                     got.size(), (got.size() > 0) ? got[0] : 7'h00);
        end
        rd_en = 0;
    endtask

    task automatic test_rollover();
        logic [6:0] got[$];
        int         when[$];
        logic [6:0] exp_ev [4];
        exp_ev = '{7'h21, 7'h61, 7'h22, 7'h62};
        rd_en = 1; rep_en = 0;
        key_ready = 1;
        for (int i = 0; i < 15; i++) begin
            key_code  = (i < 5) ? 5'h01 : 5'h02;
            key_ready = (i < 10);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL rollover_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
            if (ev_valid) begin
                got.push_back({ev_type, ev_code});
                when.push_back(cyc);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_ev[i]) begin
                errors++;
                $display("FAIL rollover_event%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 7'h00, exp_ev[i]);
            end
        end
        checks++;
        if (when.size() < 3 || (when[2] - when[1]) != 1) begin
            errors++;
            $display("FAIL rollover_gap: got %0d expected 1", (when.size() >= 3) ? when[2] - when[1] : -1);
        end
        rd_en = 0;
    endtask

    task automatic test_overflow();
        rd_en = 0; rep_en = 0; ovf_clr = 0;
        for (int i = 0; i < 13; i++) begin
            key_ready = (i < 2) || (i >= 5 && i < 7) || (i >= 10);
            key_code  = (i < 5) ? 5'h05 : ((i < 10) ? 5'h06 : 5'h07);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL ovf_fill_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        checks++;
        if ({ev_count, overflow, ev_type, ev_code} !== {3'd4, 1'b1, 2'b01, 5'h05}) begin
            errors++;
            $display("FAIL ovf_full: got cnt %0d ovf %b head %b/%h expected cnt 4 ovf 1 head 01/05",
                     ev_count, overflow, ev_type, ev_code);
        end
        ovf_clr = 1; tick(); ovf_clr = 0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        key_ready = 0;
        tick();
        rd_en = 1; tick(); rd_en = 0;
        checks++;
        if ({ev_count, overflow, ev_type, ev_code} !== {3'd4, 1'b0, 2'b11, 5'h05}) begin
            errors++;
            $display("FAIL ovf_push_pop_full: got cnt %0d ovf %b head %b/%h expected cnt 4 ovf 0 head 11/05",
                     ev_count, overflow, ev_type, ev_code);
        end
        ovf_clr = 1; key_code = 5'h08; key_ready = 1;
        tick(); tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b expected 1", overflow);
        end
        ovf_clr = 0; key_ready = 0;
        tick(); tick();
        rd_en = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL ovf_drain_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        rd_en = 0;
        ovf_clr = 1; tick(); ovf_clr = 0;
    endtask

    task automatic test_reset_mid();
        rd_en = 0; rep_en = 1;
        key_code = 5'h15; key_ready = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL rstmid_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        checks++;
        if (ev_count !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_queued: got %0d expected 2", ev_count);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({ev_valid, ev_count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL rstmid_async: got valid %b cnt %0d expected valid 0 cnt 0", ev_valid, ev_count);
        end
        model_reset();
        key_code = 5'h07;
        tick();
        rst_n = 1;
        tick();
        tick();
        checks++;
        if ({ev_valid, ev_count, ev_type, ev_code} !== {1'b1, 3'd1, 2'b01, 5'h07}) begin
            errors++;
            $display("FAIL rstmid_press: got %b cnt %0d %b/%h expected 1 cnt 1 01/07",
                     ev_valid, ev_count, ev_type, ev_code);
        end
        key_ready = 0; rd_en = 1; rep_en = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL rstmid_drain_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        rd_en = 0;
    endtask

    task automatic test_random();
        int hold_left;
        hold_left = 0;
        for (int i = 0; i < 1200; i++) begin
            if (hold_left == 0) begin
                key_ready = ($urandom_range(0, 2) != 0);
                key_code  = 5'(5'h10 + $urandom_range(0, 3));
                hold_left = $urandom_range(1, 24);
            end
            hold_left--;
            if ($urandom_range(0, 19) == 0) rep_en = ~rep_en;
            rd_en   = (i < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        key_ready = 0; rd_en = 0; ovf_clr = 0; rep_en = 0;
    endtask

    initial begin
        test_reset();
        test_tap();
        test_hold_repeat();
        test_hold_no_repeat();
        test_rollover();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
